// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO registers.
// One shared 2*WIDTH accumulator is used for both operations: shift-add for
// multiply, restoring (one trial subtract per step) for divide. Signed operations
// run on magnitudes and the sign is fixed up in a dedicated FIX cycle.
module muldiv_ctrl #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;    // quotient / product must be negated
  logic                 r_neg_r;    // remainder must be negated (takes dividend sign)
  logic                 r_zero;     // divide by zero: result is forced in FIX
  logic [WIDTH-1:0]     r_raw_a;    // untouched srca, returned as HI on divide by zero
  logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;      // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_signed;
  logic                 w_is_div;
  logic                 w_b_zero;
  logic                 w_go;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_add;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_trial;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  // Operand decode: op[0]=0 selects the signed variants, op[1]=1 selects divide.
  assign w_signed = ~op[0];
  assign w_is_div = op[1];
  assign w_b_zero = (srcb == '0);
  assign w_go     = start & ~cancel;
  assign w_abs_a  = (w_signed && srca[WIDTH-1]) ? -srca : srca;
  assign w_abs_b  = (w_signed && srcb[WIDTH-1]) ? -srcb : srcb;

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  assign w_mul_add  = r_acc[0] ? {1'b0, r_opnd} : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_mul_add;
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: shift left, try subtracting the divisor, keep it only if non-negative.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;

  // Sign correction and divide-by-zero override, consumed in FIX.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_res_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_res_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      if (r_zero) begin
        w_res_hi = r_raw_a;
        w_res_lo = '1;
      end
    end
  end

  // Sequencer: latch operands, iterate WIDTH steps, fix signs, pulse done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_raw_a  <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            r_neg_r  <= w_signed & srca[WIDTH-1];
            r_zero   <= w_is_div & w_b_zero;
            r_raw_a  <= srca;
            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_cnt    <= '0;
            r_state  <= (w_is_div && w_b_zero && ZERO_FAST) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (cancel) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            if (r_cnt == LAST_STEP) begin
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_FIX: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall = ((r_state == S_IDLE) && w_go) || (r_state == S_CALC) || (r_state == S_FIX);
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed plan vectors plus randomized operations
// checked against a plain-arithmetic reference model. Two instances share all
// inputs: one with the divide-by-zero fast path, one without.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;

  logic        stall1, busy1, done1;
  logic [31:0] hi1, lo1;
  logic        stall0, busy0, done0;
  logic [31:0] hi0, lo0;

  int n_checks = 0;
  int n_errors = 0;

  // Results captured by do_op (fast = ZERO_FAST 1, full = ZERO_FAST 0)
  int          d1_cyc, d0_cyc, n_done1, n_done0;
  logic [31:0] h1, l1, h0, l0;
  logic [63:0] stall_tr, busy_tr;

  muldiv_ctrl #(.WIDTH(32), .ZERO_FAST(1'b1)) dut_fast (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .cancel(cancel), .stall(stall1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  muldiv_ctrl #(.WIDTH(32), .ZERO_FAST(1'b0)) dut_full (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .cancel(cancel), .stall(stall0), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {HI, LO} straight from 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      default: begin
        uq = ua / ub;
        ur = ua % ub;
        r  = {ur[31:0], uq[31:0]};
      end
    endcase
    return r;
  endfunction

  // Drives one operation starting this cycle and observes ncyc cycles.
  // Operand/op inputs are scrambled after cycle 0 to expose missing latches.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int cancel_at, input int ncyc);
    d1_cyc = -1; d0_cyc = -1; n_done1 = 0; n_done0 = 0;
    stall_tr = '0; busy_tr = '0;
    h1 = 'x; l1 = 'x; h0 = 'x; l0 = 'x;
    for (int c = 0; c < ncyc; c++) begin
      start  = (c == 0);
      cancel = (c == cancel_at);
      if (c == 0) begin
        op = o; srca = a; srcb = b;
      end else begin
        op = 2'($urandom); srca = $urandom; srcb = $urandom;
      end
      @(negedge clk);
      stall_tr[c] = stall1;
      busy_tr[c]  = busy1;
      if (done1 === 1'b1) begin
        n_done1++;
        if (d1_cyc < 0) begin d1_cyc = c; h1 = hi1; l1 = lo1; end
      end
      if (done0 === 1'b1) begin
        n_done0++;
        if (d0_cyc < 0) begin d0_cyc = c; h0 = hi0; l0 = lo0; end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    cancel = 1'b0;
    $display("op=%0d a=%h b=%h cancel_at=%0d done@%0d/%0d hi=%h lo=%h",
             o, a, b, cancel_at, d1_cyc, d0_cyc, h1, l1);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'd0; srca = '0; srcb = '0;
    #3;
    n_checks++;
    if ({busy1, done1, stall1, hi1, lo1} !== 67'd0) begin
      n_errors++; $display("FAIL reset_fast: got %h want 0", {busy1, done1, stall1, hi1, lo1});
    end
    n_checks++;
    if ({busy0, done0, stall0, hi0, lo0} !== 67'd0) begin
      n_errors++; $display("FAIL reset_full: got %h want 0", {busy0, done0, stall0, hi0, lo0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy1, done1, stall1} !== 3'b000) begin
      n_errors++; $display("FAIL reset_release: got %b want 000", {busy1, done1, stall1});
    end
  endtask

  task automatic test_multu_latency();
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 36);
    n_checks++;
    if (d1_cyc !== 34) begin n_errors++; $display("FAIL multu_lat_fast: got %0d want 34", d1_cyc); end
    n_checks++;
    if (d0_cyc !== 34) begin n_errors++; $display("FAIL multu_lat_full: got %0d want 34", d0_cyc); end
    n_checks++;
    if ({h1, l1} !== 64'hFFFF_FFFE_0000_0001) begin
      n_errors++; $display("FAIL multu_result: got %h_%h want fffffffe_00000001", h1, l1);
    end
    n_checks++;
    if (stall_tr[35:0] !== {2'b00, {34{1'b1}}}) begin
      n_errors++; $display("FAIL multu_stall: got %h want %h", stall_tr[35:0], {2'b00, {34{1'b1}}});
    end
    n_checks++;
    if (busy_tr[35:0] !== {1'b0, {34{1'b1}}, 1'b0}) begin
      n_errors++; $display("FAIL multu_busy: got %h want %h", busy_tr[35:0], {1'b0, {34{1'b1}}, 1'b0});
    end
    n_checks++;
    if (n_done1 !== 1) begin n_errors++; $display("FAIL multu_pulses: got %0d want 1", n_done1); end
  endtask

  task automatic test_known_ops();
    logic [1:0]  vo[6] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [31:0] va[6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd9};
    logic [31:0] vb[6] = '{32'd7, 32'h8000_0000, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd3};
    logic [63:0] ve[6] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                           64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                           64'h0000_0000_8000_0000, 64'h0000_0000_0000_0003};
    for (int i = 0; i < 6; i++) begin
      do_op(vo[i], va[i], vb[i], -1, 36);
      n_checks++;
      if (d1_cyc !== 34 || d0_cyc !== 34) begin
        n_errors++; $display("FAIL known[%0d] latency: got %0d/%0d want 34", i, d1_cyc, d0_cyc);
      end
      n_checks++;
      if ({h1, l1} !== ve[i]) begin
        n_errors++; $display("FAIL known[%0d] fast: got %h_%h want %h", i, h1, l1, ve[i]);
      end
      n_checks++;
      if ({h0, l0} !== ve[i]) begin
        n_errors++; $display("FAIL known[%0d] full: got %h_%h want %h", i, h0, l0, ve[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    do_op(2'd3, 32'h0000_1234, 32'd0, -1, 36);
    n_checks++;
    if (d1_cyc !== 2) begin n_errors++; $display("FAIL divz_lat_fast: got %0d want 2", d1_cyc); end
    n_checks++;
    if (d0_cyc !== 34) begin n_errors++; $display("FAIL divz_lat_full: got %0d want 34", d0_cyc); end
    n_checks++;
    if ({h1, l1} !== 64'h0000_1234_FFFF_FFFF) begin
      n_errors++; $display("FAIL divz_fast: got %h_%h want 00001234_ffffffff", h1, l1);
    end
    n_checks++;
    if ({h0, l0} !== 64'h0000_1234_FFFF_FFFF) begin
      n_errors++; $display("FAIL divz_full: got %h_%h want 00001234_ffffffff", h0, l0);
    end
    n_checks++;
    if (stall_tr[2:0] !== 3'b011) begin
      n_errors++; $display("FAIL divz_stall: got %b want 011", stall_tr[2:0]);
    end
    do_op(2'd2, 32'hFFFF_FF00, 32'd0, -1, 36);
    n_checks++;
    if ({h1, l1, h0, l0} !== {32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_FFFF}) begin
      n_errors++; $display("FAIL divz_signed: got %h_%h %h_%h want ffffff00_ffffffff", h1, l1, h0, l0);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int          exp_lat;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255));
      exp = ref_model(o, a, b);
      exp_lat = (o[1] && b == 32'd0) ? 2 : 34;
      do_op(o, a, b, -1, 36);
      n_checks++;
      if (d1_cyc !== exp_lat || d0_cyc !== 34) begin
        n_errors++; $display("FAIL rand[%0d] latency: got %0d/%0d want %0d/34", i, d1_cyc, d0_cyc, exp_lat);
      end
      n_checks++;
      if ({h1, l1} !== exp || {h0, l0} !== exp) begin
        n_errors++; $display("FAIL rand[%0d] op=%0d a=%h b=%h: got %h_%h/%h_%h want %h",
                             i, o, a, b, h1, l1, h0, l0, exp);
      end
    end
  endtask

  task automatic test_cancel_back_to_back();
    do_op(2'd3, 32'd100, 32'd7, -1, 36);
    n_checks++;
    if ({h1, l1} !== 64'h0000_0002_0000_000E) begin
      n_errors++; $display("FAIL cancel_setup: got %h_%h want 00000002_0000000e", h1, l1);
    end
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 11);
    n_checks++;
    if (n_done1 !== 0 || n_done0 !== 0) begin
      n_errors++; $display("FAIL cancel_nodone: got %0d/%0d pulses want 0", n_done1, n_done0);
    end
    n_checks++;
    if ({hi1, lo1, hi0, lo0} !== {64'h0000_0002_0000_000E, 64'h0000_0002_0000_000E}) begin
      n_errors++; $display("FAIL cancel_hold: got %h_%h %h_%h want 00000002_0000000e", hi1, lo1, hi0, lo0);
    end
    do_op(2'd1, 32'd6, 32'd7, -1, 36);
    n_checks++;
    if (busy_tr[0] !== 1'b0 || stall_tr[0] !== 1'b1) begin
      n_errors++; $display("FAIL b2b_idle: got busy=%b stall=%b want 0/1", busy_tr[0], stall_tr[0]);
    end
    n_checks++;
    if (d1_cyc !== 34 || {h1, l1} !== 64'd42) begin
      n_errors++; $display("FAIL b2b_result: got %0d %h_%h want 34 00000000_0000002a", d1_cyc, h1, l1);
    end
    start = 1'b1; cancel = 1'b1; op = 2'd1; srca = 32'd3; srcb = 32'd3;
    @(negedge clk);
    n_checks++;
    if (stall1 !== 1'b0) begin n_errors++; $display("FAIL start_cancel_stall: got %b want 0", stall1); end
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL start_cancel_busy: got %b want 0", busy1); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, 20);
    n_checks++;
    if (busy_tr[19] !== 1'b1) begin n_errors++; $display("FAIL midop_busy: got %b want 1", busy_tr[19]); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy1, done1, stall1, hi1, lo1, busy0, done0, stall0, hi0, lo0} !== 134'd0) begin
      n_errors++; $display("FAIL midop_reset: got %h_%h busy=%b stall=%b want all 0", hi1, lo1, busy1, stall1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_op(2'd3, 32'd9, 32'd3, -1, 36);
    n_checks++;
    if (d1_cyc !== 34 || {h1, l1} !== 64'h0000_0000_0000_0003) begin
      n_errors++; $display("FAIL after_reset: got %0d %h_%h want 34 00000000_00000003", d1_cyc, h1, l1);
    end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_known_ops();
    test_div_zero();
    test_random();
    test_cancel_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
